// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, port count and arbiter state encoding.
package noc_pkg;

  localparam int unsigned PORT_N  = 0;
  localparam int unsigned PORT_S  = 1;
  localparam int unsigned PORT_E  = 2;
  localparam int unsigned PORT_W  = 3;
  localparam int unsigned PORT_L  = 4;
  localparam int unsigned N_PORTS = 5;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/noc_out_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port switch arbiter.
// With NOC_ARB_WATCHDOG_EN defined the bundle also carries wdog_err_o.
interface noc_out_arbiter_if #(
  parameter int unsigned N_PORTS = noc_pkg::N_PORTS,
  parameter int unsigned OWN_W   = $clog2(noc_pkg::N_PORTS)
);

  logic [N_PORTS-1:0] req_i;
  logic [N_PORTS-1:0] head_i;
  logic [N_PORTS-1:0] tail_i;
  logic               credit_en_i;
  logic [N_PORTS-1:0] gnt_o;
  logic               decr_o;
  logic               locked_o;
  logic [OWN_W-1:0]   owner_o;
`ifdef NOC_ARB_WATCHDOG_EN
  logic               wdog_err_o;

  modport master (
    output req_i, head_i, tail_i, credit_en_i,
    input  gnt_o, decr_o, locked_o, owner_o, wdog_err_o
  );

  modport slave (
    input  req_i, head_i, tail_i, credit_en_i,
    output gnt_o, decr_o, locked_o, owner_o, wdog_err_o
  );
`else
  modport master (
    output req_i, head_i, tail_i, credit_en_i,
    input  gnt_o, decr_o, locked_o, owner_o
  );

  modport slave (
    input  req_i, head_i, tail_i, credit_en_i,
    output gnt_o, decr_o, locked_o, owner_o
  );
`endif

endinterface

// File: rtl/noc_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of cand scanning ptr+1, ptr+2, ...
// modulo N. Shared with the VC and input allocators.
module rr_pick #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);

  always_comb begin
    int unsigned idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!valid && cand[idx]) begin
        valid  = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Per-output switch arbiter: round-robin among head flits, holds the output head-to-tail,
// gates every transfer on credit_en_i. NOC_ARB_WATCHDOG_EN adds a BUSY stall watchdog.
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N_PORTS     = noc_pkg::N_PORTS,
  parameter int unsigned OWN_W       = $clog2(noc_pkg::N_PORTS),
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  noc_out_arbiter_if.slave  arb
);

  arb_state_e         state;
  logic [OWN_W-1:0]   owner;
  logic [OWN_W-1:0]   ptr;
  logic [N_PORTS-1:0] cand;
  logic [N_PORTS-1:0] gnt;
  logic [OWN_W-1:0]   winner;
  logic               winner_vld;
  logic               idle_grant;
  logic               busy_grant;

  assign cand = arb.req_i & arb.head_i;

  rr_pick #(
    .N (N_PORTS),
    .W (OWN_W)
  ) u_rr_pick (
    .cand   (cand),
    .ptr    (ptr),
    .winner (winner),
    .valid  (winner_vld)
  );

  assign idle_grant = !reset && (state == ARB_IDLE) && winner_vld && arb.credit_en_i;
  assign busy_grant = !reset && (state == ARB_BUSY) && arb.req_i[owner] && arb.credit_en_i;

  always_comb begin
    gnt = '0;
    if (idle_grant) begin
      gnt[winner] = 1'b1;
    end else if (busy_grant) begin
      gnt[owner] = 1'b1;
    end
  end

  assign arb.gnt_o    = gnt;
  assign arb.decr_o   = |gnt;
  assign arb.locked_o = (state == ARB_BUSY);
  assign arb.owner_o  = owner;

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wdog_err;

  assign arb.wdog_err_o = wdog_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= '0;
      ptr   <= OWN_W'(N_PORTS - 1);
`ifdef NOC_ARB_WATCHDOG_EN
      wd_cnt   <= '0;
      wdog_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (idle_grant) begin
            if (arb.tail_i[winner]) begin
              ptr <= winner;
            end else begin
              state <= ARB_BUSY;
              owner <= winner;
            end
          end
`ifdef NOC_ARB_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        ARB_BUSY: begin
          if (busy_grant) begin
            if (arb.tail_i[owner]) begin
              state <= ARB_IDLE;
              ptr   <= owner;
            end
`ifdef NOC_ARB_WATCHDOG_EN
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LIMIT) begin
            // Stalled owner is evicted and demoted to lowest priority, as a tail would.
            state    <= ARB_IDLE;
            ptr      <= owner;
            wdog_err <= 1'b1;
            wd_cnt   <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Scoreboard bench for noc_out_arbiter: driver queues hand-computed expectations per
// cycle, a negedge monitor pops and compares. Define NOC_ARB_WATCHDOG_EN for the watchdog case.
module tb_noc_out_arbiter;

  localparam int unsigned NP   = 5;
  localparam int unsigned OW   = 3;
`ifdef NOC_ARB_WATCHDOG_EN
  localparam int unsigned WDOG = 8;
`else
  localparam int unsigned WDOG = 64;
`endif

  typedef struct {
    logic [NP-1:0] gnt;
    logic          decr;
    logic          locked;
    logic [OW-1:0] owner;
    logic          wdog;
    string         tag;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  noc_out_arbiter_if #(.N_PORTS(NP), .OWN_W(OW)) bus ();

  noc_out_arbiter #(
    .N_PORTS     (NP),
    .OWN_W       (OW),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [NP-1:0] req, input logic [NP-1:0] head,
                      input logic [NP-1:0] tail, input logic cr, input logic [NP-1:0] eg,
                      input logic el, input logic [OW-1:0] eo, input logic ew, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = r;
    bus.req_i       = req;
    bus.head_i      = head;
    bus.tail_i      = tail;
    bus.credit_en_i = cr;
    e.gnt    = eg;
    e.decr   = |eg;
    e.locked = el;
    e.owner  = eo;
    e.wdog   = ew;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.gnt_o !== e.gnt) begin
        failures++;
        $display("FAIL %s gnt_o got=%b want=%b", e.tag, bus.gnt_o, e.gnt);
      end
      checks++;
      if (bus.decr_o !== e.decr) begin
        failures++;
        $display("FAIL %s decr_o got=%b want=%b", e.tag, bus.decr_o, e.decr);
      end
      checks++;
      if (bus.locked_o !== e.locked) begin
        failures++;
        $display("FAIL %s locked_o got=%b want=%b", e.tag, bus.locked_o, e.locked);
      end
      checks++;
      if (bus.owner_o !== e.owner) begin
        failures++;
        $display("FAIL %s owner_o got=%0d want=%0d", e.tag, bus.owner_o, e.owner);
      end
`ifdef NOC_ARB_WATCHDOG_EN
      checks++;
      if (bus.wdog_err_o !== e.wdog) begin
        failures++;
        $display("FAIL %s wdog_err_o got=%b want=%b", e.tag, bus.wdog_err_o, e.wdog);
      end
`endif
    end
  end

  initial begin
    reset           = 1'b1;
    bus.req_i       = '0;
    bus.head_i      = '0;
    bus.tail_i      = '0;
    bus.credit_en_i = 1'b0;

    // reset: grants suppressed even with every port requesting
    step(1, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0, "rst_hold");
    step(1, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0, "rst_hold2");

    // single-flit on port 0, zero latency, ptr -> 0
    step(0, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 0, 0, 0, "single_p0");

    // reset again so ptr=4, then all ports single-flit
    step(1, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, "rst_rr");
    step(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00001, 0, 0, 0, "rr0");
    step(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00010, 0, 0, 0, "rr1");
    step(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00100, 0, 0, 0, "rr2");
    step(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b01000, 0, 0, 0, "rr3");
    step(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b10000, 0, 0, 0, "rr4");
    step(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00001, 0, 0, 0, "rr5");

    // ptr=0: port 2 four-flit packet beats pending port 0 head
    step(0, 5'b00101, 5'b00101, 5'b00000, 1, 5'b00100, 0, 0, 0, "pkt2_head");
    step(0, 5'b00101, 5'b00001, 5'b00000, 1, 5'b00100, 1, 2, 0, "pkt2_body1");
    step(0, 5'b00101, 5'b00001, 5'b00000, 1, 5'b00100, 1, 2, 0, "pkt2_body2");
    step(0, 5'b00101, 5'b00001, 5'b00100, 1, 5'b00100, 1, 2, 0, "pkt2_tail");
    step(0, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 0, 2, 0, "p0_after");

    // ptr=0: port 1 packet, 3-cycle credit stall, a bubble, then tail
    step(0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00010, 0, 2, 0, "pkt1_head");
    step(0, 5'b00011, 5'b00001, 5'b00000, 0, 5'b00000, 1, 1, 0, "stall1");
    step(0, 5'b00011, 5'b00001, 5'b00000, 0, 5'b00000, 1, 1, 0, "stall2");
    step(0, 5'b00011, 5'b00001, 5'b00000, 0, 5'b00000, 1, 1, 0, "stall3");
    step(0, 5'b00001, 5'b00001, 5'b00000, 1, 5'b00000, 1, 1, 0, "bubble");
    step(0, 5'b00011, 5'b00001, 5'b00010, 1, 5'b00010, 1, 1, 0, "pkt1_tail");

    // ptr=1, IDLE: head without credit, then tail without head
    step(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00000, 0, 1, 0, "idle_nocredit");
    step(0, 5'b00100, 5'b00000, 5'b00100, 1, 5'b00000, 0, 1, 0, "idle_nohead");

    // ptr=1: port 3 packet, reset while BUSY, then port 0 wins from ptr=4
    step(0, 5'b01000, 5'b01000, 5'b00000, 1, 5'b01000, 0, 1, 0, "pkt3_head");
    step(0, 5'b01000, 5'b00000, 5'b00000, 1, 5'b01000, 1, 3, 0, "pkt3_body");
    step(1, 5'b01001, 5'b01001, 5'b00000, 1, 5'b00000, 1, 3, 0, "rst_busy");
    step(0, 5'b01001, 5'b01001, 5'b01001, 1, 5'b00001, 0, 0, 0, "post_rst_p0");
    step(0, 5'b01000, 5'b01000, 5'b01000, 1, 5'b01000, 0, 0, 0, "post_rst_p3");

`ifdef NOC_ARB_WATCHDOG_EN
    // ptr=3: port 4 sends head then drops req; evicted after 8 stalled cycles
    step(0, 5'b10000, 5'b10000, 5'b00000, 1, 5'b10000, 0, 0, 0, "wd_head");
    for (int i = 0; i < 8; i++)
      step(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 1, 4, 0, "wd_stall");
    step(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 4, 1, "wd_fired");
    // ptr=4 after eviction: port 0 next, error stays set
    step(0, 5'b10001, 5'b10001, 5'b10001, 1, 5'b00001, 0, 4, 1, "wd_sticky");
    step(1, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 4, 1, "wd_rst");
    step(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, "wd_cleared");
`endif

    @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.req_i = '0;
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
